// File: rtl/resp_mux_pkg.sv
// Shared types and response codes for the slave response multiplexer.
// Imported by resp_mux_n and its wait counter.
package resp_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

endpackage

// File: rtl/resp_timeout_ctr.sv
// Saturating wait counter; expired_o flags the cycle whose
// increment would reach TIMEOUT. TIMEOUT=0 never expires.
module resp_timeout_ctr
    import resp_mux_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIM = (TIMEOUT > 0) ? TIMEOUT : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != CW'(LIM)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT > 0) && en_i
                       && (cnt_q == CW'(LIM - 1));

endmodule

// File: rtl/resp_mux_n.sv
// N-way slave response multiplexer with decode-error and
// wait-timeout handling.
module resp_mux_n #(
    parameter int NSLV    = 5,
    parameter int DW      = 32,
    parameter int RW      = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSLV-1:0]      sel,
    input  logic                 sel_valid,
    input  logic [NSLV*DW-1:0]   rdata_in,
    input  logic [NSLV-1:0]      ready_in,
    input  logic [NSLV*RW-1:0]   resp_in,
    output logic [DW-1:0]        rdata_final,
    output logic                 ready_final,
    output logic [RW-1:0]        resp_final,
    output logic                 busy,
    output logic                 err_decode,
    output logic                 err_timeout
);
    import resp_mux_pkg::*;

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = $clog2(NSLV + 1);

    state_e          state_q, state_d;
    logic [NSLV-1:0] sel_q, sel_d;
    logic            err_dec_q, err_dec_d;
    logic            err_to_q, err_to_d;
    logic [CW-1:0]   ones;
    logic            onehot, accept;
    logic            wait_en, expired;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   rdata_sel;
    logic            ready_sel;
    logic [RW-1:0]   resp_sel;

    always_comb begin
        ones = '0;
        for (int i = 0; i < NSLV; i++) begin
            ones = ones + CW'(sel[i]);
        end
    end

    assign onehot = (ones == CW'(1));
    assign accept = (state_q == ST_IDLE) && sel_valid && onehot;
    assign sel_d  = accept ? sel : sel_q;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) idx = IW'(i);
        end
    end

    assign rdata_sel = rdata_in[idx*DW +: DW];
    assign ready_sel = ready_in[idx];
    assign resp_sel  = resp_in[idx*RW +: RW];
    assign wait_en   = (state_q == ST_WAIT) && !ready_sel;

    resp_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept),
        .en_i      (wait_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            err_dec_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            err_dec_q <= err_dec_d;
            err_to_q  <= err_to_d;
        end
    end

    // Ready beats expiry when both land in the same WAIT cycle.
    always_comb begin
        state_d   = state_q;
        err_dec_d = 1'b0;
        err_to_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    if (onehot) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d   = ST_ERR;
                        err_dec_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (ready_sel) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d  = ST_ERR;
                    err_to_d = 1'b1;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_final = '0;
        ready_final = 1'b1;
        resp_final  = RW'(RESP_OKAY);
        unique case (state_q)
            ST_WAIT: begin
                rdata_final = rdata_sel;
                ready_final = ready_sel;
                resp_final  = resp_sel;
            end
            ST_ERR:  resp_final = RW'(RESP_ERROR);
            default: ;
        endcase
    end

    assign busy        = (state_q == ST_WAIT);
    assign err_decode  = err_dec_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_resp_mux_n.sv
// Bench for resp_mux_n: transaction-level model with per-cycle
// compare, directed literal scenarios, 8x64 routing sweep.
`timescale 1ns/1ps
module tb_resp_mux_n;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]   sel_a, ready_a;
    logic         sv_a;
    logic [159:0] rdata_a;
    logic [9:0]   resp_a;
    logic [31:0]  rdf_a;
    logic         rdyf_a, busy_a, ed_a, et_a;
    logic [1:0]   rsf_a;

    logic [7:0]   sel_b, ready_b;
    logic         sv_b;
    logic [511:0] rdata_b;
    logic [15:0]  resp_b;
    logic [63:0]  rdf_b;
    logic         rdyf_b, busy_b, ed_b, et_b;
    logic [1:0]   rsf_b;

    int checks = 0;
    int errors = 0;

    // Model: active slave (-1 none), waits so far, pending error kind
    int m_slave = -1;
    int m_wait  = 0;
    int m_err   = 0;

    resp_mux_n #(.NSLV(5), .DW(32), .RW(2), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset(reset), .sel(sel_a), .sel_valid(sv_a),
        .rdata_in(rdata_a), .ready_in(ready_a), .resp_in(resp_a),
        .rdata_final(rdf_a), .ready_final(rdyf_a), .resp_final(rsf_a),
        .busy(busy_a), .err_decode(ed_a), .err_timeout(et_a)
    );

    resp_mux_n #(.NSLV(8), .DW(64), .RW(2), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .sel(sel_b), .sel_valid(sv_b),
        .rdata_in(rdata_b), .ready_in(ready_b), .resp_in(resp_b),
        .rdata_final(rdf_b), .ready_final(rdyf_b), .resp_final(rsf_b),
        .busy(busy_b), .err_decode(ed_b), .err_timeout(et_b)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_slave <= -1;
            m_wait  <= 0;
            m_err   <= 0;
        end else if (m_err != 0) begin
            m_err <= 0;
        end else if (m_slave >= 0) begin
            if (ready_a[m_slave]) begin
                m_slave <= -1;
            end else if (m_wait + 1 == TO) begin
                m_slave <= -1;
                m_err   <= 2;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (sv_a) begin
            if ($countones(sel_a) == 1) begin
                m_slave <= $clog2(sel_a);
                m_wait  <= 0;
            end else begin
                m_err <= 1;
            end
        end
    end

    initial begin
        forever begin
            logic [31:0] e_rd;
            logic [1:0]  e_rs;
            logic        e_rdy, e_bz, e_ed, e_et;
            @(negedge clk);
            #1;
            e_rd = '0; e_rdy = 1'b1; e_rs = 2'd0;
            e_bz = 1'b0; e_ed = 1'b0; e_et = 1'b0;
            if (m_err != 0) begin
                e_rs = 2'd1;
                e_ed = (m_err == 1);
                e_et = (m_err == 2);
            end else if (m_slave >= 0) begin
                e_rd  = rdata_a[m_slave*32 +: 32];
                e_rdy = ready_a[m_slave];
                e_rs  = resp_a[m_slave*2 +: 2];
                e_bz  = 1'b1;
            end
            chk("model_rdata", rdf_a, e_rd);
            chk("model_ready", rdyf_a, e_rdy);
            chk("model_resp", rsf_a, e_rs);
            chk("model_busy", busy_a, e_bz);
            chk("model_err_decode", ed_a, e_ed);
            chk("model_err_timeout", et_a, e_et);
        end
    end

    task automatic drive(input logic v, input logic [4:0] s,
                         input logic [4:0] r);
        @(negedge clk);
        sv_a = v;
        sel_a = s;
        ready_a = r;
    endtask

    task automatic expect_a(input string nm, input logic [31:0] rd,
                            input logic rdy, input logic [1:0] rs,
                            input logic bz, input logic ed,
                            input logic et);
        #2;
        chk({nm, "_rdata"}, rdf_a, rd);
        chk({nm, "_ready"}, rdyf_a, rdy);
        chk({nm, "_resp"}, rsf_a, rs);
        chk({nm, "_busy"}, busy_a, bz);
        chk({nm, "_err_decode"}, ed_a, ed);
        chk({nm, "_err_timeout"}, et_a, et);
    endtask

    initial begin
        sel_a = '0; sv_a = 1'b0; ready_a = '0;
        rdata_a = '0; resp_a = '0;
        sel_b = '0; sv_b = 1'b0; ready_b = '0;
        rdata_b = '0; resp_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        drive(0, 5'b00000, 5'b00000);
        expect_a("reset_idle", 32'h0, 1, 2'd0, 0, 0, 0);

        // Slave 2 answers on the 4th WAIT cycle, the last before expiry
        rdata_a[2*32 +: 32] = 32'hCAFE_0002;
        resp_a[2*2 +: 2] = 2'b10;
        drive(1, 5'b00100, 5'b00000);
        expect_a("s2_addr", 32'h0, 1, 2'd0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 5'b11111, 5'b00000);
            expect_a("s2_wait", 32'hCAFE_0002, 0, 2'b10, 1, 0, 0);
        end
        drive(0, 5'b00000, 5'b00100);
        expect_a("s2_data", 32'hCAFE_0002, 1, 2'b10, 1, 0, 0);
        drive(0, 5'b00000, 5'b00000);
        expect_a("s2_done", 32'h0, 1, 2'd0, 0, 0, 0);

        drive(1, 5'b00110, 5'b00000);
        expect_a("multi_addr", 32'h0, 1, 2'd0, 0, 0, 0);
        drive(0, 5'b00000, 5'b00000);
        expect_a("multi_err", 32'h0, 1, 2'b01, 0, 1, 0);
        drive(1, 5'b00000, 5'b00000);
        expect_a("multi_after", 32'h0, 1, 2'd0, 0, 0, 0);
        drive(0, 5'b00000, 5'b00000);
        expect_a("zero_err", 32'h0, 1, 2'b01, 0, 1, 0);
        drive(0, 5'b00000, 5'b00000);
        expect_a("zero_after", 32'h0, 1, 2'd0, 0, 0, 0);

        rdata_a[1*32 +: 32] = 32'h1234_0001;
        resp_a[1*2 +: 2] = 2'b11;
        drive(1, 5'b00010, 5'b00000);
        expect_a("to_addr", 32'h0, 1, 2'd0, 0, 0, 0);
        for (int k = 0; k < TO; k++) begin
            drive(0, 5'b00000, 5'b11101);
            expect_a("to_wait", 32'h1234_0001, 0, 2'b11, 1, 0, 0);
        end
        drive(0, 5'b00000, 5'b00000);
        expect_a("to_err", 32'h0, 1, 2'b01, 0, 0, 1);
        drive(0, 5'b00000, 5'b00000);
        expect_a("to_after", 32'h0, 1, 2'd0, 0, 0, 0);

        rdata_a[0 +: 32] = 32'h0000_AAAA;
        resp_a[0 +: 2] = 2'b00;
        rdata_a[3*32 +: 32] = 32'h3333_3333;
        drive(1, 5'b00001, 5'b00000);
        expect_a("rst_addr", 32'h0, 1, 2'd0, 0, 0, 0);
        drive(1, 5'b01000, 5'b01000);
        expect_a("ign_valid", 32'h0000_AAAA, 0, 2'd0, 1, 0, 0);
        drive(0, 5'b00000, 5'b01000);
        expect_a("rst_wait2", 32'h0000_AAAA, 0, 2'd0, 1, 0, 0);
        reset = 1'b1;
        expect_a("rst_mid", 32'h0, 1, 2'd0, 0, 0, 0);
        drive(0, 5'b00000, 5'b00000);
        reset = 1'b0;
        expect_a("rst_rel", 32'h0, 1, 2'd0, 0, 0, 0);
        drive(0, 5'b00000, 5'b00000);
        expect_a("rst_quiet", 32'h0, 1, 2'd0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rdata_b[i*64 +: 64] = 64'hB0B0_0000_0000_0000
                                  + 64'(i) * 64'h1_0000_0001;
            resp_b[i*2 +: 2] = 2'(i);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sv_b = 1'b1;
            sel_b = 8'(1 << i);
            ready_b = 8'h00;
            @(negedge clk);
            sv_b = 1'b0;
            ready_b = 8'hFF;
            #2;
            chk("route_rdata", rdf_b,
                64'hB0B0_0000_0000_0000 + 64'(i) * 64'h1_0000_0001);
            chk("route_resp", rsf_b, 64'(i % 4));
            chk("route_ready", rdyf_b, 1);
            chk("route_busy", busy_b, 1);
            @(negedge clk);
            ready_b = 8'h00;
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(199) == 0);
            sv_a = 1'($urandom_range(1));
            case ($urandom_range(9))
                0: sel_a = 5'b00000;
                1, 2: sel_a = 5'($urandom);
                default: sel_a = 5'(1 << $urandom_range(4));
            endcase
            for (int i = 0; i < 5; i++) begin
                ready_a[i] = ($urandom_range(3) == 0);
                rdata_a[i*32 +: 32] = $urandom;
            end
            resp_a = 10'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        sv_a = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/resp_mux_n.md
RESP_MUX_N -- requirements
Module: resp_mux_n

Interface
REQ-001 Parameter NSLV, default 5, number of slave response channels (2..16).
REQ-002 Parameter DW, default 32, read-data width per slave.
REQ-003 Parameter RW, default 2, response-code width per slave.
REQ-004 Parameter TIMEOUT, default 16, maximum wait cycles per transfer; 0 disables timeout.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 sel  input  NSLV  one-hot slave select; bit i selects slave i.
REQ-008 sel_valid  input  1  address-phase strobe; sel is sampled when high.
REQ-009 rdata_in  input  NSLV*DW  slave i data in slice [i*DW +: DW].
REQ-010 ready_in  input  NSLV  slave i ready in bit i.
REQ-011 resp_in  input  NSLV*RW  slave i response in slice [i*RW +: RW].
REQ-012 rdata_final  output  DW  muxed read data.
REQ-013 ready_final  output  1  muxed ready.
REQ-014 resp_final  output  RW  muxed response.
REQ-015 busy  output  1  high while a transfer is outstanding (WAIT state).
REQ-016 err_decode  output  1  one-cycle pulse on an invalid select.
REQ-017 err_timeout  output  1  one-cycle pulse on a timeout abort.

Function
REQ-018 FSM states: IDLE, WAIT, ERR.
REQ-019 IDLE: rdata_final=0, ready_final=1, resp_final=OKAY (0).
REQ-020 IDLE with sel_valid=1 and sel one-hot: register sel, clear the wait counter, go to WAIT on the next edge.
REQ-021 IDLE with sel_valid=1 and sel zero or multi-hot: go to ERR; err_decode pulses in the ERR cycle.
REQ-022 WAIT: outputs combinationally forward the registered slave's rdata/ready/resp, so data-phase latency is one cycle after the sel_valid edge.
REQ-023 WAIT with the selected ready_in=1: go to IDLE on the next edge.
REQ-024 WAIT with ready_in=0: increment the wait counter; when it reaches TIMEOUT, go to ERR and pulse err_timeout in the ERR cycle.
REQ-025 The slave ready wins if it is asserted in the same cycle the counter reaches TIMEOUT; no timeout is raised.
REQ-026 ERR, exactly one cycle: rdata_final=0, ready_final=1, resp_final=ERROR (1), then return to IDLE.
REQ-027 sel_valid in WAIT or ERR is ignored; sel changes outside IDLE do not affect the registered select.
REQ-028 The wait counter width is $clog2(TIMEOUT+1) and saturates; TIMEOUT=0 means the counter never expires.
REQ-029 No output contains a latch; every output has a defined value in every state.

Reset
REQ-030 Asynchronous reset: state=IDLE, registered select=0, counter=0, err pulses=0.
REQ-031 Outputs during and after reset: rdata_final=0, ready_final=1, resp_final=OKAY, busy=0.
REQ-032 Reset mid-WAIT or mid-ERR aborts the transfer immediately with no error pulse.

Structure
REQ-033 Package resp_mux_pkg holds the state enum and the constants RESP_OKAY=2'b00 and RESP_ERROR=2'b01.
REQ-034 One sub-module, resp_timeout_ctr (parametrised by TIMEOUT, with clear/enable/expired ports), implements the wait counter.
REQ-035 The one-hot check and the index decode are local combinational logic in resp_mux_n.

Verification
REQ-036 Reset, then idle -> ready_final=1, resp_final=0, rdata_final=0, busy=0.
REQ-037 sel=5'b00100 with sel_valid; slave 2 ready after 3 cycles with rdata 32'hCAFE_0002 -> busy for 3 cycles, then ready_final=1 with rdata_final=32'hCAFE_0002 and resp_final=slave 2's resp.
REQ-038 sel=5'b00110, then sel=5'b00000 -> each gives one ERR cycle with resp_final=2'b01, ready_final=1, and one err_decode pulse.
REQ-039 TIMEOUT=4, selected slave never ready -> 4 WAIT cycles, then ERR with err_timeout=1; a ready asserted in cycle 4 instead completes OKAY.
REQ-040 Reset asserted on the 2nd WAIT cycle -> immediate IDLE outputs, no error pulse; sel_valid during WAIT is ignored.
REQ-041 NSLV=8, DW=64 instance, each slave 0..7 in turn -> correct slice routing.
